inst_sequencer: RTL and testbench

Multi-cycle control sequencer for the RV32 core datapath. It fetches an instruction over a valid/request handshake and holds it in an instruction register that feeds the combinational instruction decoder. It then steps the datapath through DECODE, EXEC, optional CSR and WB states. Per state it drives the register-file, CSR and writeback-select strobes, halting on any opcode outside the supported R/I/U/CSRRW set.

---
 rtl/inst_sequencer.sv | 159 +++++++++++++++
 tb/tb_inst_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_sequencer.sv
// Multi-cycle control sequencer for the RV32 datapath: fetch handshake, instruction
// register, and per-state register-file/CSR/writeback strobes. Unsupported opcodes halt in TRAP.
module inst_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  input  logic        stall,
  output logic [31:0] pc,
  output logic        alu_src_imm,
  output logic [1:0]  wb_sel,
  output logic        rf_we,
  output logic        csr_we,
  output logic        retire,
  output logic [31:0] instret,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_CSR    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    T_R   = 2'd0,
    T_I   = 2'd1,
    T_U   = 2'd2,
    T_CSR = 2'd3
  } itype_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_U   = 7'b0110111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_IMU = 2'b01;
  localparam logic [1:0] WB_CSR = 2'b10;

  state_e      state_q, state_d;
  itype_e      itype_q, itype_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] instret_q, instret_d;
  logic        alu_src_imm_q, alu_src_imm_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic        illegal_q, illegal_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FETCH;
      itype_q       <= T_R;
      pc_q          <= RESET_PC;
      inst_q        <= 32'h0;
      instret_q     <= 32'h0;
      alu_src_imm_q <= 1'b0;
      wb_sel_q      <= WB_ALU;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      itype_q       <= itype_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      instret_q     <= instret_d;
      alu_src_imm_q <= alu_src_imm_d;
      wb_sel_q      <= wb_sel_d;
      illegal_q     <= illegal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    itype_d       = itype_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    instret_d     = instret_q;
    alu_src_imm_d = alu_src_imm_q;
    wb_sel_d      = wb_sel_q;
    illegal_d     = illegal_q;
    imem_req      = 1'b0;
    rf_we         = 1'b0;
    csr_we        = 1'b0;
    retire        = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          inst_d  = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        if (inst_q[6:0] == OP_R) begin
          itype_d       = T_R;
          alu_src_imm_d = 1'b0;
          wb_sel_d      = WB_ALU;
        end else if (inst_q[6:0] == OP_I) begin
          itype_d       = T_I;
          alu_src_imm_d = 1'b1;
          wb_sel_d      = WB_ALU;
        end else if (inst_q[6:0] == OP_U) begin
          itype_d       = T_U;
          alu_src_imm_d = 1'b0;
          wb_sel_d      = WB_IMU;
        end else if (inst_q[6:0] == OP_SYS && inst_q[14:12] == 3'b001) begin
          itype_d       = T_CSR;
          alu_src_imm_d = 1'b0;
          wb_sel_d      = WB_CSR;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (!stall) state_d = (itype_q == T_CSR) ? S_CSR : S_WB;
      end
      S_CSR: begin
        csr_we  = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        // x0 is hardwired to zero, so a write to it is suppressed here
        rf_we     = (inst_q[11:7] != 5'd0);
        retire    = 1'b1;
        pc_d      = pc_q + PC_STEP;
        instret_d = instret_q + 32'd1;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        illegal_d = 1'b1;
      end
      default: begin
        state_d   = S_TRAP;
        illegal_d = 1'b1;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign inst        = inst_q;
  assign instret     = instret_q;
  assign alu_src_imm = alu_src_imm_q;
  assign wb_sel      = wb_sel_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: table of instructions with hand-computed
// strobes/latencies, plus hand sequences for mid-instruction reset and TRAP.
module tb_inst_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        stall;
  logic [31:0] pc;
  logic        alu_src_imm;
  logic [1:0]  wb_sel;
  logic        rf_we;
  logic        csr_we;
  logic        retire;
  logic [31:0] instret;
  logic        illegal;

  inst_sequencer #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .inst(inst), .stall(stall), .pc(pc),
    .alu_src_imm(alu_src_imm), .wb_sel(wb_sel),
    .rf_we(rf_we), .csr_we(csr_we), .retire(retire),
    .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          wait_n;   // FETCH cycles with imem_valid low before the fetch
    int          stall_n;  // extra EXEC cycles
    bit          pulse;    // pulse imem_valid with other data during EXEC
    bit          ill;
    logic        alu;
    logic [1:0]  wb;
    bit          rf;
    bit          csr;
  } vec_t;

  localparam int NV = 8;
  localparam int N_LEGAL = 6;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_mis = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] exp_instret = 32'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h", name, act, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, imem_req, 1);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_instret"}, instret, 32'h0);
    chk({tag, "_strobes"}, {29'd0, rf_we, csr_we, retire}, 32'h0);
    chk({tag, "_alu_wb"}, {29'd0, alu_src_imm, wb_sel}, 32'h0);
    chk({tag, "_illegal"}, illegal, 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k, rf_n, csr_n, ret_n, ret_k, csr_k, bad_n;
    bit done, req_seen;
    string t;
    t = $sformatf("v%0d", idx);
    for (int w = 0; w < v.wait_n; w++) begin
      imem_valid = 1'b0;
      chk({t, "_wait_req"}, imem_req, 1);
      step();
    end
    chk({t, "_fetch_req"}, imem_req, 1);
    chk({t, "_fetch_addr"}, imem_addr, exp_pc);
    imem_valid = 1'b1;
    imem_rdata = v.word;
    step();
    imem_valid = 1'b0;
    chk({t, "_inst"}, inst, v.word);
    if (v.ill) begin
      step();
      chk({t, "_illegal"}, illegal, 1);
      bad_n = 0;
      for (int c = 0; c < 20; c++) begin
        imem_valid = c[0];
        imem_rdata = 32'h0050_0093;
        stall = c[1];
        if (rf_we || csr_we || retire || imem_req) bad_n++;
        if (pc !== exp_pc || inst !== v.word || illegal !== 1'b1) bad_n++;
        step();
      end
      chk({t, "_trap_quiet"}, bad_n, 0);
      imem_valid = 1'b0;
      stall = 1'b0;
      reset = 1'b1;
      #1;
      chk_reset_vals({t, "_trap_rst"});
      step();
      reset = 1'b0;
      exp_pc = 32'h0;
      exp_instret = 32'h0;
      return;
    end
    k = 2;
    rf_n = 0; csr_n = 0; ret_n = 0; ret_k = 0; csr_k = 0;
    done = 1'b0;
    req_seen = 1'b0;
    while (!done && k < 40) begin
      stall = (k >= 3 && k <= 2 + v.stall_n);
      if (v.pulse && k == 3) begin
        imem_valid = 1'b1;
        imem_rdata = ~v.word;
      end else begin
        imem_valid = 1'b0;
      end
      if (k == 3) begin
        chk({t, "_alu_src_imm"}, alu_src_imm, v.alu);
        chk({t, "_wb_sel"}, wb_sel, v.wb);
      end
      if (imem_req) req_seen = 1'b1;
      if (rf_we) rf_n++;
      if (csr_we) begin csr_n++; csr_k = k; end
      if (retire) begin ret_n++; ret_k = k; done = 1'b1; end
      step();
      k++;
    end
    stall = 1'b0;
    imem_valid = 1'b0;
    exp_pc = exp_pc + 32'd4;
    exp_instret = exp_instret + 32'd1;
    chk({t, "_retire_n"}, ret_n, 1);
    chk({t, "_retire_cycle"}, ret_k, 4 + v.stall_n + (v.csr ? 1 : 0));
    chk({t, "_rf_we_n"}, rf_n, v.rf ? 1 : 0);
    chk({t, "_csr_we_n"}, csr_n, v.csr ? 1 : 0);
    if (v.csr) chk({t, "_csr_cycle"}, csr_k, 4 + v.stall_n);
    chk({t, "_req_outside_fetch"}, req_seen, 0);
    chk({t, "_inst_kept"}, inst, v.word);
    chk({t, "_pc"}, pc, exp_pc);
    chk({t, "_addr"}, imem_addr, exp_pc);
    chk({t, "_instret"}, instret, exp_instret);
    chk({t, "_illegal"}, illegal, 0);
  endtask

  task automatic reset_in_exec();
    imem_valid = 1'b1;
    imem_rdata = 32'h0050_0093;
    step();
    imem_valid = 1'b0;
    step();
    stall = 1'b1;
    chk("mid_alu_src_imm", alu_src_imm, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    step();
    chk("mid_rst_held_pc", pc, 32'h0);
    reset = 1'b0;
    stall = 1'b0;
    exp_pc = 32'h0;
    exp_instret = 32'h0;
  endtask

  initial begin
    vecs[0] = '{32'h0050_0093, 0, 0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0}; // addi x1,x0,5
    vecs[1] = '{32'h0020_81B3, 0, 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0}; // add x3,x1,x2
    vecs[2] = '{32'h3402_9073, 0, 0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1}; // csrrw x0,mscratch,t0
    vecs[3] = '{32'h1234_52B7, 5, 0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0}; // lui x5
    vecs[4] = '{32'h0000_0013, 1, 1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0}; // nop (rd=x0)
    vecs[5] = '{32'h3402_90F3, 0, 2, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1}; // csrrw x1
    vecs[6] = '{32'h0000_006F, 0, 0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0}; // jal (unsupported)
    vecs[7] = '{32'h3020_0073, 0, 0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0}; // mret (funct3 000)

    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    stall = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk_reset_vals("por");
    step();
    step();
    reset = 1'b0;
    chk_reset_vals("por_release");

    for (int i = 0; i < NV; i++) begin
      if (i == N_LEGAL) reset_in_exec();
      run_vec(i, vecs[i]);
    end
    run_vec(0, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
